// File: rtl/serializador_piso.sv
// Parallel-in / serial-out shifter: captures a WIDTH-bit word on load and
// drives it onto a single serial line, one bit per clock, with busy/done framing.
module serializador_piso #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             done_reg;

  logic [WIDTH-1:0] sr_next;
  logic             head_bit;

  // The output end of the register is fixed by bit order; vacated bits fill with 0.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_next  = {sr_reg[WIDTH-2:0], 1'b0};
      assign head_bit = sr_reg[WIDTH-1];
    end else begin : g_lsb
      assign sr_next  = {1'b0, sr_reg[WIDTH-1:1]};
      assign head_bit = sr_reg[0];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            sr_reg    <= D;
            cnt_reg   <= CW'(WIDTH - 1);
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          // load is deliberately ignored here, including on the final bit.
          if (cnt_reg != '0) begin
            sr_reg  <= sr_next;
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == SHIFT);
  assign out  = busy & head_bit;
  assign done = done_reg;

endmodule

// File: tb/tb_serializador_piso.sv
// Scoreboard bench for serializador_piso: MSB-first instance with a loopback
// receiver, plus an LSB-first instance; monitors compare on every busy/done cycle.
module tb_serializador_piso;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic         load, load_l;
  logic [W-1:0] D, D_l;
  logic         out, busy, done;
  logic         out_l, busy_l, done_l;
  logic [W-1:0] rq;

  int checks = 0;
  int errors = 0;

  logic   exp_q[$];
  logic   exp_l[$];
  logic [W-1:0] word_q[$];

  serializador_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset), .load(load), .D(D),
    .out(out), .busy(busy), .done(done)
  );

  serializador_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .load(load_l), .D(D_l),
    .out(out_l), .busy(busy_l), .done(done_l)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Receiver model: 4-bit serial-in shift register, new bit enters at Q0.
  always @(posedge clock or negedge reset) begin
    if (!reset) rq <= '0;
    else        rq <= {rq[W-2:0], out};
  end

  function automatic void check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endfunction

  // Monitor for the MSB-first instance.
  initial begin : mon_msb
    logic prev_busy;
    int   run;
    logic [W-1:0] w;
    prev_busy = 1'b0;
    run = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("rst_busy", busy, 0);
        check("rst_out", out, 0);
        check("rst_done", done, 0);
        prev_busy = 1'b0;
        run = 0;
      end else if (busy) begin
        check("busy_no_done", done, 0);
        if (exp_q.size() == 0) check("bit_unexpected", 1, 0);
        else check("msb_bit", out, exp_q.pop_front());
        run++;
        prev_busy = 1'b1;
      end else begin
        check("idle_out", out, 0);
        check("done_pulse", done, prev_busy);
        if (prev_busy) begin
          check("busy_len", run, W);
          if (word_q.size() == 0) check("word_unexpected", 1, 0);
          else begin
            w = word_q.pop_front();
            check("loopback", rq, w);
          end
        end
        run = 0;
        prev_busy = 1'b0;
      end
    end
  end

  // Monitor for the LSB-first instance.
  initial begin : mon_lsb
    logic prev_busy;
    int   run;
    prev_busy = 1'b0;
    run = 0;
    forever begin
      @(negedge clock);
      if (reset && busy_l) begin
        if (exp_l.size() == 0) check("lsb_unexpected", 1, 0);
        else check("lsb_bit", out_l, exp_l.pop_front());
        run++;
        prev_busy = 1'b1;
      end else if (reset) begin
        check("lsb_done", done_l, prev_busy);
        if (prev_busy) check("lsb_len", run, W);
        run = 0;
        prev_busy = 1'b0;
      end else begin
        prev_busy = 1'b0;
        run = 0;
      end
    end
  end

  task automatic push_msb(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
    word_q.push_back(w);
  endtask

  task automatic send(input logic [W-1:0] w);
    @(negedge clock);
    load = 1'b1;
    D    = w;
    push_msb(w);
    @(negedge clock);
    load = 1'b0;
    D    = 4'b0000;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check({name, "_timeout"}, 0, 1);
    @(negedge clock);
  endtask

  logic [W-1:0] vec[3];

  initial begin
    reset = 1'b0; load = 1'b0; D = '0; load_l = 1'b0; D_l = '0;
    vec[0] = 4'b1101; vec[1] = 4'b0010; vec[2] = 4'b1111;

    // Reset state without any clock edge.
    #1;
    check("init_busy", busy, 0);
    check("init_out", out, 0);
    check("init_done", done, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;

    // MSB-first 1011.
    send(4'b1011);
    wait_done("msb");

    // LSB-first 1000 on the second instance.
    @(negedge clock);
    load_l = 1'b1; D_l = 4'b1000;
    for (int i = 0; i < W; i++) exp_l.push_back(D_l[i]);
    @(negedge clock);
    load_l = 1'b0; D_l = 4'b1111;
    repeat (6) @(negedge clock);
    check("lsb_drained", exp_l.size(), 0);

    // Load held through the transfer: 0110 ignored until the edge after done.
    @(negedge clock);
    load = 1'b1; D = 4'b1011; push_msb(4'b1011);
    @(negedge clock);
    D = 4'b0110; push_msb(4'b0110);
    repeat (5) @(negedge clock);
    load = 1'b0; D = 4'b0000;
    wait_done("hold");
    check("hold_drained", exp_q.size(), 0);

    // Reset during idle.
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("idle_rst_busy", busy, 0);
    check("idle_rst_out", out, 0);
    @(negedge clock);
    #2 reset = 1'b1;

    // Reset mid-transfer after 2 bits of 1111, then a clean 0101.
    send(4'b1111);
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("mid_rst_busy", busy, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    word_q.delete();
    @(negedge clock);
    #2 reset = 1'b1;
    send(4'b0101);
    wait_done("after_rst");

    // Loopback into the receiver model.
    for (int k = 0; k < 3; k++) begin
      send(vec[k]);
      wait_done("loop");
    end

    repeat (2) @(negedge clock);
    check("final_drained", exp_q.size() + word_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
